// File: rtl/key_event_decoder.sv
// Turns one debounced key level into registered single-cycle press/short/long/repeat events.
// Optional double-click detection is compiled in with `define KEY_DOUBLE_CLICK_EN.
module key_event_decoder #(
   parameter logic        KEY_ACTIVE_LEVEL = 1'b0,
   parameter int unsigned LONG_CYCLES      = 25_000_000,
   parameter int unsigned REPEAT_CYCLES    = 5_000_000,
   parameter int unsigned DCLICK_CYCLES    = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic press_pulse,
   output logic short_press,
   output logic long_press,
   output logic repeat_pulse,
   output logic double_click,
   output logic key_held
);

   localparam int unsigned MAX_LR     = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES
                                                                      : REPEAT_CYCLES;
   localparam int unsigned MAX_CYCLES = (MAX_LR > DCLICK_CYCLES) ? MAX_LR : DCLICK_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
`ifdef KEY_DOUBLE_CLICK_EN
   localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StHeld  = 3'd1,
      StLong  = 3'd2
`ifdef KEY_DOUBLE_CLICK_EN
      ,
      StWait2 = 3'd3,
      StHeld2 = 3'd4
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             key_d_q, key_d_d;
   logic             press_pulse_q, press_pulse_d;
   logic             short_press_q, short_press_d;
   logic             long_press_q, long_press_d;
   logic             repeat_pulse_q, repeat_pulse_d;
   logic             key_held_q, key_held_d;
   logic             pressed, prev_pressed, press_edge, rel_edge;

   assign pressed      = (key_in == KEY_ACTIVE_LEVEL);
   assign prev_pressed = (key_d_q == KEY_ACTIVE_LEVEL);
   assign press_edge   = pressed & ~prev_pressed;
   assign rel_edge     = ~pressed & prev_pressed;
   // Saturating increment: the counter never wraps back to zero.
   assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef KEY_DOUBLE_CLICK_EN
   logic double_click_q, double_click_d;
`endif

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_inc;
      key_d_d        = key_in;
      press_pulse_d  = 1'b0;
      short_press_d  = 1'b0;
      long_press_d   = 1'b0;
      repeat_pulse_d = 1'b0;
`ifdef KEY_DOUBLE_CLICK_EN
      double_click_d = 1'b0;
`endif

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (press_edge) begin
               state_d       = StHeld;
               press_pulse_d = 1'b1;
            end
         end

         StHeld: begin
            // A release in the threshold cycle still counts as a short press.
            if (rel_edge) begin
               cnt_d = '0;
`ifdef KEY_DOUBLE_CLICK_EN
               state_d = StWait2;
`else
               state_d       = StIdle;
               short_press_d = 1'b1;
`endif
            end else if (cnt_q == LONG_LAST) begin
               state_d      = StLong;
               cnt_d        = '0;
               long_press_d = 1'b1;
            end
         end

         StLong: begin
            if (rel_edge) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == REPEAT_LAST) begin
               cnt_d          = '0;
               repeat_pulse_d = 1'b1;
            end
         end

`ifdef KEY_DOUBLE_CLICK_EN
         StWait2: begin
            // Timeout wins over a press landing on the last window cycle.
            if (cnt_q == DCLICK_LAST) begin
               state_d       = StIdle;
               cnt_d         = '0;
               short_press_d = 1'b1;
            end else if (press_edge) begin
               state_d       = StHeld2;
               cnt_d         = '0;
               press_pulse_d = 1'b1;
            end
         end

         StHeld2: begin
            if (rel_edge) begin
               state_d        = StIdle;
               cnt_d          = '0;
               double_click_d = 1'b1;
            end else if (cnt_q == LONG_LAST) begin
               state_d      = StLong;
               cnt_d        = '0;
               long_press_d = 1'b1;
            end
         end
`endif

         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

`ifdef KEY_DOUBLE_CLICK_EN
      key_held_d = (state_d == StHeld) || (state_d == StLong) || (state_d == StHeld2);
`else
      key_held_d = (state_d == StHeld) || (state_d == StLong);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         key_d_q        <= KEY_ACTIVE_LEVEL;
         press_pulse_q  <= 1'b0;
         short_press_q  <= 1'b0;
         long_press_q   <= 1'b0;
         repeat_pulse_q <= 1'b0;
         key_held_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         key_d_q        <= key_d_d;
         press_pulse_q  <= press_pulse_d;
         short_press_q  <= short_press_d;
         long_press_q   <= long_press_d;
         repeat_pulse_q <= repeat_pulse_d;
         key_held_q     <= key_held_d;
      end
   end

`ifdef KEY_DOUBLE_CLICK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         double_click_q <= 1'b0;
      end else begin
         double_click_q <= double_click_d;
      end
   end

   assign double_click = double_click_q;
`else
   assign double_click = 1'b0;
`endif

   assign press_pulse  = press_pulse_q;
   assign short_press  = short_press_q;
   assign long_press   = long_press_q;
   assign repeat_pulse = repeat_pulse_q;
   assign key_held     = key_held_q;

endmodule
